alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that executes integer multiply (low WIDTH bits of product) by sequencing the shared ALU through shift-add iterations.
- Sits beside the ALU control unit. While it owns the ALU it drives the ALU operands and operation code through the datapath ALU mux, and it stalls the core via busy_o.
- Uses only existing ALU operation codes: ADD = 4'b0000 and SLL = 4'b0101.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ALU_ADD, 4'b0000, ALU operation code for add.
- ALU_SLL, 4'b0101, ALU operation code for shift-left-logical.
- ALU_NOP, 4'b1111, operation code driven when the sequencer does not own the ALU.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request a multiply; sampled only in IDLE.
- multiplicand_i  input  WIDTH  operand A (rs1), latched on accepted start.
- multiplier_i  input  WIDTH  operand B (rs2), latched on accepted start.
- alu_result_i  input  WIDTH  combinational result of the shared ALU.
- alu_sel_o  output  1  1 = datapath ALU mux selects sequencer operands/op.
- alu_a_o  output  WIDTH  ALU operand A.
- alu_b_o  output  WIDTH  ALU operand B.
- alu_op_o  output  4  ALU operation code.
- busy_o  output  1  core stall request.
- done_o  output  1  one-cycle completion pulse.
- result_o  output  WIDTH  product low WIDTH bits; holds until next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE.
  - P, M, Q, count = 0.
  - busy_o = 0, done_o = 0, alu_sel_o = 0, result_o = 0.
  - alu_a_o = 0, alu_b_o = 0, alu_op_o = ALU_NOP.
  - No done pulse follows a reset.
- Internal registers: P (accumulator), M (shifted multiplicand), Q (remaining multiplier), count (0..WIDTH).
- FSM states: IDLE, CHECK, ADD, SHIFT, DONE.
- IDLE:
  - busy_o = 0.
  - If start_i = 1: P <= 0, M <= multiplicand_i, Q <= multiplier_i, count <= 0, then go to CHECK.
- CHECK:
  - If Q == 0 or count == WIDTH, go to DONE.
  - Else if Q[0] = 1, go to ADD.
  - Else go to SHIFT.
  - The ALU is not used in this state.
- ADD:
  - alu_sel_o = 1, alu_op_o = ALU_ADD, alu_a_o = P, alu_b_o = M.
  - P <= alu_result_i, then go to SHIFT.
- SHIFT:
  - alu_sel_o = 1, alu_op_o = ALU_SLL, alu_a_o = M, alu_b_o = 1.
  - M <= alu_result_i, Q <= Q >> 1 (zero fill), count <= count + 1, then go to CHECK.
- DONE:
  - done_o = 1, result_o <= P, then go to IDLE.
- busy_o = 1 in CHECK, ADD, SHIFT and DONE.
- Outside ADD and SHIFT: alu_sel_o = 0, alu_op_o = ALU_NOP, alu_a_o = 0, alu_b_o = 0.
- Arithmetic:
  - All sums are truncated to WIDTH bits.
  - The low WIDTH bits are identical for signed and unsigned operands; no sign handling is needed.
- Latency:
  - done_o is high in the cycle N clock edges after the edge that sampled start_i.
  - N = 2 + 2*k + ones, where k = position of the highest set bit of multiplier_i plus 1 (0 if multiplier_i = 0), and ones = popcount(multiplier_i).
  - Minimum N = 2 (multiplier = 0). Maximum N = 3*WIDTH + 2.
- result_o is valid in the cycle after done_o and holds until the next accepted start.
- start_i is ignored in every non-IDLE state, including DONE; no queuing.
- Operand inputs are only sampled when start is accepted; later changes have no effect.
- The count == WIDTH guard is defensive only. Q always reaches 0 within WIDTH shifts.

Test Plan:
- Basic multiply: reset, then start with A = 3, B = 5.
  - Expect busy_o high from edge 1.
  - Expect alu_sel_o/op sequence ADD, SLL, SLL, ADD, SLL.
  - Expect done_o exactly at N = 10, result_o = 15, busy_o low after DONE.
- Zero multiplier: A = 0x1234, B = 0.
  - Expect N = 2, no ALU cycles (alu_sel_o never high), result_o = 0.
- Worst case with wrap: A = 0xFFFF_FFFF, B = 0xFFFF_FFFF.
  - Expect N = 98, result_o = 0x0000_0001.
  - Signed check: A = -3 (0xFFFF_FFFD), B = 7, expect result_o = 0xFFFF_FFEB.
- Start ignored while busy: pulse start_i with new operands during ADD/SHIFT and during DONE.
  - Expect the original product and only one done_o pulse.
  - Expect the next start in IDLE to be accepted normally.
- Reset mid-operation: assert reset during SHIFT of A = 6, B = 9.
  - Expect immediate (asynchronous) busy_o = 0, alu_op_o = 4'b1111, result_o = 0, no done_o.
  - A new start afterwards gives result_o = 54.
- Operand stability and ALU release: change multiplicand_i/multiplier_i after acceptance.
  - Expect no effect on the result.
  - Expect alu_sel_o = 0 and alu_op_o = 4'b1111 in every IDLE, CHECK and DONE cycle.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU for ADD/SLL steps.
// Returns the low WIDTH bits of multiplicand * multiplier and stalls the core while active.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0000,
  parameter logic [3:0]  ALU_SLL = 4'b0101,
  parameter logic [3:0]  ALU_NOP = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_op_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath update for the shift-add iteration.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    q_d      = q_q;
    count_d  = count_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          p_d     = '0;
          m_d     = multiplicand_i;
          q_d     = multiplier_i;
          count_d = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((q_q == '0) || (count_q == CNT_W'(WIDTH))) begin
          state_d = S_DONE;
        end else if (q_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD: begin
        p_d     = alu_result_i;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        m_d     = alu_result_i;
        q_d     = q_q >> 1;
        count_d = count_q + CNT_W'(1);
        state_d = S_CHECK;
      end
      S_DONE: begin
        result_d = p_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register cleanly yet line up
  // with the cycle in which the sequencer owns the ALU.
  always_comb begin
    alu_sel_d = 1'b0;
    alu_op_d  = ALU_NOP;
    alu_a_d   = '0;
    alu_b_d   = '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);

    case (state_d)
      S_ADD: begin
        alu_sel_d = 1'b1;
        alu_op_d  = ALU_ADD;
        alu_a_d   = p_d;
        alu_b_d   = m_d;
      end
      S_SHIFT: begin
        alu_sel_d = 1'b1;
        alu_op_d  = ALU_SLL;
        alu_a_d   = m_d;
        alu_b_d   = WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      result_q  <= '0;
      alu_sel_q <= 1'b0;
      alu_op_q  <= ALU_NOP;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      count_q   <= count_d;
      result_q  <= result_d;
      alu_sel_q <= alu_sel_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign alu_sel_o = alu_sel_q;
  assign alu_op_o  = alu_op_q;
  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU plus a multiply/trace reference model.
// Every cycle of each multiply is compared against the expected ALU usage and handshake.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [W-1:0]  multiplicand_i;
  logic [W-1:0]  multiplier_i;
  logic [W-1:0]  alu_result_i;
  logic          alu_sel_o;
  logic [W-1:0]  alu_a_o;
  logic [W-1:0]  alu_b_o;
  logic [3:0]    alu_op_o;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  result_o;

  int            errors;
  int            checks;
  logic [W-1:0]  prev_result;

  alu_mul_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .alu_result_i   (alu_result_i),
    .alu_sel_o      (alu_sel_o),
    .alu_a_o        (alu_a_o),
    .alu_b_o        (alu_b_o),
    .alu_op_o       (alu_op_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_o       (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU behaviour; unknown ops return a recognisable junk value.
  always_comb begin
    if (alu_op_o == OP_ADD)      alu_result_i = alu_a_o + alu_b_o;
    else if (alu_op_o == OP_SLL) alu_result_i = alu_a_o << alu_b_o[4:0];
    else                         alu_result_i = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [W-1:0] exp_res);
    chk({tag, " busy"},   W'(busy_o),    W'(1'b0));
    chk({tag, " done"},   W'(done_o),    W'(1'b0));
    chk({tag, " sel"},    W'(alu_sel_o), W'(1'b0));
    chk({tag, " op"},     W'(alu_op_o),  W'(OP_NOP));
    chk({tag, " a"},      alu_a_o,       '0);
    chk({tag, " b"},      alu_b_o,       '0);
    chk({tag, " result"}, result_o,      exp_res);
  endtask

  // Runs one multiply starting from IDLE; returns with the DUT back in IDLE.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [3:0]   eop [0:3*W+3];
    logic [W-1:0] ea  [0:3*W+3];
    logic [W-1:0] eb  [0:3*W+3];
    logic [W-1:0] p;
    logic [W-1:0] prod;
    int           n;
    int           k;

    k = 0;
    for (int i = 0; i < int'(W); i++) if (b[i]) k = i + 1;
    // Cycle trace: CHECK, then per bit [ADD] SLL CHECK, finally DONE.
    p = '0;
    n = 1;
    eop[n] = OP_NOP; ea[n] = '0; eb[n] = '0;
    for (int i = 0; i < k; i++) begin
      if (b[i]) begin
        n++; eop[n] = OP_ADD; ea[n] = p; eb[n] = a << i;
        p = p + (a << i);
      end
      n++; eop[n] = OP_SLL; ea[n] = a << i; eb[n] = W'(1);
      n++; eop[n] = OP_NOP; ea[n] = '0; eb[n] = '0;
    end
    n++; eop[n] = OP_NOP; ea[n] = '0; eb[n] = '0;
    prod = a * b;

    start_i        = 1'b1;
    multiplicand_i = a;
    multiplier_i   = b;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      multiplicand_i = $urandom;
      multiplier_i   = $urandom;
      start_i        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("run busy",   W'(busy_o),    W'(1'b1));
      chk("run done",   W'(done_o),    W'(c == n));
      chk("run sel",    W'(alu_sel_o), W'(eop[c] != OP_NOP));
      chk("run op",     W'(alu_op_o),  W'(eop[c]));
      chk("run a",      alu_a_o,       ea[c]);
      chk("run b",      alu_b_o,       eb[c]);
      chk("run hold",   result_o,      prev_result);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk_idle("after", prod);
    prev_result = prod;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    prev_result    = '0;
    reset          = 1'b1;
    start_i        = 1'b0;
    multiplicand_i = '0;
    multiplier_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset", '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_idle("post reset", '0);

    run_mul(32'd3, 32'd5, 1'b0);
    chk("basic 3x5", result_o, 32'd15);
    run_mul(32'h0000_1234, 32'd0, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("wrap", result_o, 32'h0000_0001);
    run_mul(32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("signed", result_o, 32'hFFFF_FFEB);
    run_mul(32'd11, 32'd13, 1'b1);
    chk("noisy 11x13", result_o, 32'd143);
    run_mul(32'd2, 32'h8000_0000, 1'b1);

    // Asynchronous reset in the middle of a SHIFT cycle.
    start_i = 1'b1; multiplicand_i = 32'd6; multiplier_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("mid op", W'(alu_op_o), W'(OP_ADD));
    @(posedge clk); #1;
    chk("mid op", W'(alu_op_o), W'(OP_SLL));
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async reset", '0);
    @(posedge clk); #1;
    reset = 1'b0;
    prev_result = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk_idle("quiet", '0);
    end
    run_mul(32'd6, 32'd9, 1'b0);
    chk("after reset 6x9", result_o, 32'd54);

    for (int t = 0; t < 20; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (t % 3 == 1) rb = rb >> $urandom_range(0, 31);
      run_mul(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
